instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 188 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Purpose: turns a decoded instruction request (format class, func3, alt bit,
// register indices, pre-signed byte immediate) into a 32-bit RV32I word and
// queues it together with its byte address in a small output FIFO. Illegal
// requests are consumed, produce a one-cycle err pulse and are dropped.
//
// Ports:
//   clk, rst            sole clock; asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready low only when FIFO full)
//   in_class            0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI,
//                       6 AUIPC, 7 JAL, 8 JALR, 9-15 illegal
//   in_func3, in_alt    func3 field and SUB/SRA select
//   in_rd/rs1/rs2       register indices
//   in_imm              byte immediate, already sign-extended
//   out_valid/out_ready FIFO head handshake
//   out_instr/out_addr  encoded head word and its byte address (0 when empty)
//   err                 one-cycle pulse after an illegal request is accepted
//   count               FIFO occupancy
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_class,
  input  logic [2:0]             in_func3,
  input  logic                   in_alt,
  input  logic [REG_SEL-1:0]     in_rd,
  input  logic [REG_SEL-1:0]     in_rs1,
  input  logic [REG_SEL-1:0]     in_rs2,
  input  logic [31:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE-1:0]   out_instr,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [4:0]           w_rd;
  logic [4:0]           w_rs1;
  logic [4:0]           w_rs2;
  logic [31:0]          w_enc;
  logic                 w_legal;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;

  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [CNT_W-1:0]     r_count;
  logic [ADDR_W-1:0]    r_wrAddr;
  logic                 r_err;
  logic [WORD_SIZE-1:0] r_instrMem [DEPTH];
  logic [ADDR_W-1:0]    r_addrMem  [DEPTH];

  // Register fields are always 5 bits in the RV32I layout regardless of how
  // wide the index ports are.
  assign w_rd  = 5'(in_rd);
  assign w_rs1 = 5'(in_rs1);
  assign w_rs2 = 5'(in_rs2);

  // Combinational encoder and legality check. Every class builds its word
  // directly from the request; anything outside the supported subset clears
  // w_legal so the request is consumed but never enqueued.
  always_comb begin
    w_enc   = '0;
    w_legal = 1'b1;
    case (in_class)
      4'd0: begin
        // The alt bit only selects SUB/SRA; for every other func3 it is dropped.
        w_enc = {((in_alt && (in_func3 == 3'b000 || in_func3 == 3'b101)) ? 7'b0100000 : 7'b0000000),
                 w_rs2, w_rs1, in_func3, w_rd, OP_R};
      end
      4'd1: begin
        // Shifts carry a 5-bit shamt with the SRAI marker in bit 30.
        if (in_func3 == 3'b001 || in_func3 == 3'b101) begin
          w_enc = {1'b0, (in_alt && (in_func3 == 3'b101)), 5'b00000, in_imm[4:0],
                   w_rs1, in_func3, w_rd, OP_I};
        end else begin
          w_enc = {in_imm[11:0], w_rs1, in_func3, w_rd, OP_I};
        end
      end
      4'd2: begin
        w_enc   = {in_imm[11:0], w_rs1, in_func3, w_rd, OP_LOAD};
        w_legal = !(in_func3 == 3'b011 || in_func3 == 3'b110 || in_func3 == 3'b111);
      end
      4'd3: begin
        w_enc   = {in_imm[11:5], w_rs2, w_rs1, in_func3, in_imm[4:0], OP_STORE};
        w_legal = (in_func3 <= 3'b010);
      end
      4'd4: begin
        w_enc   = {in_imm[12], in_imm[10:5], w_rs2, w_rs1, in_func3,
                   in_imm[4:1], in_imm[11], OP_BRANCH};
        w_legal = !(in_func3 == 3'b010 || in_func3 == 3'b011) && !in_imm[0];
      end
      4'd5: begin
        w_enc = {in_imm[31:12], w_rd, OP_LUI};
      end
      4'd6: begin
        w_enc = {in_imm[31:12], w_rd, OP_AUIPC};
      end
      4'd7: begin
        w_enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], w_rd, OP_JAL};
        w_legal = !in_imm[0];
      end
      4'd8: begin
        w_enc = {in_imm[11:0], w_rs1, 3'b000, w_rd, OP_JALR};
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Handshake decode. A full FIFO refuses requests even when the head is
  // leaving this cycle, and an empty FIFO never forwards a word in the same
  // cycle it arrives.
  assign in_ready = (r_count != CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = !w_empty && out_ready;

  // Pointer, occupancy, write address and error pulse. The write address only
  // moves for words that are actually enqueued, so rejected requests leave it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_wrAddr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_push) begin
        r_wrPtr  <= r_wrPtr + PTR_W'(1);
        r_wrAddr <= r_wrAddr + ADDR_W'(4);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage. Contents need no reset because the head is masked to zero
  // whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instrMem[r_wrPtr] <= WORD_SIZE'(w_enc);
      r_addrMem[r_wrPtr]  <= r_wrAddr;
    end
  end

  assign out_valid = !w_empty;
  assign out_instr = w_empty ? '0 : r_instrMem[r_rdPtr];
  assign out_addr  = w_empty ? '0 : r_addrMem[r_rdPtr];
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Purpose: self-checking bench for instr_encoder. Directed scenarios for the
// reference words, error rejection, back-pressure, reset and address wrap,
// followed by a randomized phase. Expected words come from an arithmetic
// reference encoder and a queue that stands in for the FIFO.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 12;
  localparam int REG_SEL = 5;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               inValid = 1'b0;
  logic               inReady;
  logic [3:0]         inClass = '0;
  logic [2:0]         inFunc3 = '0;
  logic               inAlt = 1'b0;
  logic [REG_SEL-1:0] inRd = '0;
  logic [REG_SEL-1:0] inRs1 = '0;
  logic [REG_SEL-1:0] inRs2 = '0;
  logic [31:0]        inImm = '0;
  logic               outValid;
  logic               outReady = 1'b0;
  logic [31:0]        outInstr;
  logic [ADDR_W-1:0]  outAddr;
  logic               err;
  logic [2:0]         count;

  int     checks = 0;
  int     errors = 0;
  int     addrModel = 0;
  bit     lastAccepted = 1'b0;
  entry_t sb[$];

  instr_encoder #(
    .WORD_SIZE(32), .NUM_REGS(32), .REG_SEL(REG_SEL), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .in_class(inClass), .in_func3(inFunc3), .in_alt(inAlt),
    .in_rd(inRd), .in_rs1(inRs1), .in_rs2(inRs2), .in_imm(inImm),
    .out_valid(outValid), .out_ready(outReady),
    .out_instr(outInstr), .out_addr(outAddr),
    .err(err), .count(count)
  );

  always #5 clk = ~clk;

  // Reference encoder: each field is placed by shifting and adding, following
  // the RV32I field placement for each format.
  function automatic logic [31:0] refEncode(input logic [31:0] cls, input logic [31:0] f3,
                                            input logic [31:0] alt, input logic [31:0] rd,
                                            input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [31:0] imm);
    logic [31:0] w;
    w = 0;
    case (cls)
      0: w = 32'h33 + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
             + ((alt != 0 && (f3 == 0 || f3 == 5)) ? (32'd1 << 30) : 0);
      1: if (f3 == 1 || f3 == 5)
           w = 32'h13 + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((imm & 31) << 20)
               + ((alt != 0 && f3 == 5) ? (32'd1 << 30) : 0);
         else
           w = 32'h13 + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((imm & 32'hFFF) << 20);
      2: w = 32'h03 + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((imm & 32'hFFF) << 20);
      3: w = 32'h23 + ((imm & 31) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
             + (((imm >> 5) & 127) << 25);
      4: w = 32'h63 + (((imm >> 11) & 1) << 7) + (((imm >> 1) & 15) << 8) + (f3 << 12)
             + (rs1 << 15) + (rs2 << 20) + (((imm >> 5) & 63) << 25) + (((imm >> 12) & 1) << 31);
      5: w = 32'h37 + (rd << 7) + (imm & 32'hFFFFF000);
      6: w = 32'h17 + (rd << 7) + (imm & 32'hFFFFF000);
      7: w = 32'h6F + (rd << 7) + (((imm >> 12) & 255) << 12) + (((imm >> 11) & 1) << 20)
             + (((imm >> 1) & 1023) << 21) + (((imm >> 20) & 1) << 31);
      8: w = 32'h67 + (rd << 7) + (rs1 << 15) + ((imm & 32'hFFF) << 20);
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit refLegal(input logic [31:0] cls, input logic [31:0] f3,
                                  input logic [31:0] imm);
    if (cls > 8) return 1'b0;
    if (cls == 4 && (f3 == 2 || f3 == 3)) return 1'b0;
    if (cls == 2 && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b0;
    if (cls == 3 && f3 > 2) return 1'b0;
    if ((cls == 4 || cls == 7) && imm[0]) return 1'b0;
    return 1'b1;
  endfunction

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] cls, input logic [2:0] f3,
                               input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm, input logic ordy);
    inValid  = v;
    inClass  = cls;
    inFunc3  = f3;
    inAlt    = alt;
    inRd     = rd;
    inRs1    = rs1;
    inRs2    = rs2;
    inImm    = imm;
    outReady = ordy;
  endtask

  // One clock cycle: check the head and handshake against the model before
  // the edge, update the model, then check err/count after the edge.
  task automatic clockStep();
    bit     full;
    bit     accept;
    bit     legal;
    bit     expErr;
    entry_t e;
    full = (sb.size() == DEPTH);
    checkOutput("inReady", {31'd0, inReady}, {31'd0, !full});
    checkOutput("outValid", {31'd0, outValid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      checkOutput("headInstr", outInstr, sb[0].instr);
      checkOutput("headAddr", 32'(outAddr), sb[0].addr);
    end
    accept = inValid && !full;
    legal  = refLegal(32'(inClass), 32'(inFunc3), inImm);
    lastAccepted = accept;
    if (sb.size() != 0 && outReady) void'(sb.pop_front());
    if (accept && legal) begin
      e.instr = refEncode(32'(inClass), 32'(inFunc3), 32'(inAlt), 32'(inRd),
                          32'(inRs1), 32'(inRs2), inImm);
      e.addr  = 32'(addrModel);
      sb.push_back(e);
      addrModel = (addrModel + 4) % (1 << ADDR_W);
    end
    expErr = accept && !legal;
    @(posedge clk);
    #1;
    checkOutput("err", {31'd0, err}, {31'd0, expErr});
    checkOutput("count", 32'(count), 32'(sb.size()));
  endtask

  // Asserts reset in the middle of a cycle and checks that everything clears
  // without waiting for a clock edge.
  task automatic doReset();
    inValid  = 1'b0;
    outReady = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rstCount", 32'(count), 32'd0);
    checkOutput("rstOutValid", {31'd0, outValid}, 32'd0);
    checkOutput("rstInReady", {31'd0, inReady}, 32'd1);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    checkOutput("rstInstr", outInstr, 32'd0);
    checkOutput("rstAddr", 32'(outAddr), 32'd0);
    sb.delete();
    addrModel = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  cls;
    logic [31:0] imm;

    // Power-on reset and the single R-type reference word.
    doReset();
    applyStimulus(1, 0, 3'b000, 0, 3, 1, 2, 32'd0, 0);
    clockStep();
    checkOutput("r21Valid", {31'd0, outValid}, 32'd1);
    checkOutput("r21Instr", outInstr, 32'h002081B3);
    checkOutput("r21Addr", 32'(outAddr), 32'h000);

    // SUB followed by ADDI with all-ones immediate, then branch encodings.
    doReset();
    applyStimulus(1, 0, 3'b000, 1, 5, 6, 7, 32'd0, 0);
    clockStep();
    applyStimulus(1, 1, 3'b000, 0, 1, 0, 0, 32'hFFFFFFFF, 0);
    clockStep();
    checkOutput("subInstr", outInstr, 32'h407302B3);
    checkOutput("subAddr", 32'(outAddr), 32'h000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
    clockStep();
    checkOutput("addiInstr", outInstr, 32'hFFF00093);
    checkOutput("addiAddr", 32'(outAddr), 32'h004);
    applyStimulus(1, 4, 3'b000, 0, 0, 1, 2, 32'd8, 1);
    clockStep();
    checkOutput("beqInstr", outInstr, 32'h00208463);
    checkOutput("beqAddr", 32'(outAddr), 32'h008);
    applyStimulus(1, 4, 3'b000, 0, 0, 1, 2, 32'd3, 0);
    clockStep();
    checkOutput("oddBranchErr", {31'd0, err}, 32'd1);
    checkOutput("oddBranchCount", 32'(count), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
    clockStep();
    applyStimulus(1, 4, 3'b000, 0, 0, 1, 2, 32'd8, 1);
    clockStep();
    checkOutput("afterErrAddr", 32'(outAddr), 32'h00C);

    // Back-pressure: four words fill the FIFO, the fifth stalls, then drain.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 3'b000, 0, 5'(i + 1), 1, 2, 32'd0, 0);
      clockStep();
    end
    checkOutput("fullInReady", {31'd0, inReady}, 32'd0);
    checkOutput("fullCount", 32'(count), 32'd4);
    applyStimulus(1, 0, 3'b000, 0, 5, 1, 2, 32'd0, 0);
    clockStep();
    checkOutput("stallCount", 32'(count), 32'd4);
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clockStep();
      if (lastAccepted) inValid = 1'b0;
    end
    checkOutput("drainedCount", 32'(count), 32'd0);

    // Reset with words queued discards them; addressing restarts at zero.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5, 3'b000, 0, 5'(i), 0, 0, 32'h12345000, 0);
      clockStep();
    end
    checkOutput("queued3", 32'(count), 32'd3);
    doReset();
    applyStimulus(1, 0, 3'b000, 0, 3, 1, 2, 32'd0, 0);
    clockStep();
    checkOutput("postRstAddr", 32'(outAddr), 32'h000);
    checkOutput("postRstInstr", outInstr, 32'h002081B3);

    // Randomized traffic, mostly legal, with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      cls = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      imm = $urandom();
      if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
      applyStimulus(($urandom_range(0, 9) < 7), cls, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    imm, ($urandom_range(0, 9) < 7));
      clockStep();
    end

    // Address wrap: 1024 words fill the 12-bit byte space, the next is at 0.
    doReset();
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1, 5, 3'b000, 0, 5'($urandom_range(0, 31)), 0, 0, $urandom(), 1);
      clockStep();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
    for (int i = 0; i < 3; i++) clockStep();
    applyStimulus(1, 0, 3'b000, 0, 3, 1, 2, 32'd0, 0);
    clockStep();
    checkOutput("wrapAddr", 32'(outAddr), 32'h000);
    checkOutput("wrapInstr", outInstr, 32'h002081B3);

    $display("[TB] directed and random phases complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
